// File: rtl/vTPU_pkg.sv
// Shared types and default geometry for the vTPU operand loaders.
package vTPU_pkg;

  typedef enum logic {
    LD_WEIGHT = 1'b0,
    LD_ACC    = 1'b1
  } loader_kind_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } loader_state_e;

  localparam int LD_ROWS   = 4;
  localparam int LD_ELEMS  = 8;
  localparam int LD_ELEM_W = 16;
  localparam int LD_META_W = 2;

endpackage

// File: rtl/loader_meta_fifo.sv
// Metadata FIFO for the operand row loader; push is refused when full, pop when empty.
module loader_meta_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/operand_row_loader.sv
// Assembles a ROWS x ELEMS tile from a little-endian byte stream, pairing each
// weight element with one metadata entry; accumulator tiles carry zero metadata.
module operand_row_loader
  import vTPU_pkg::*;
#(
  parameter int ROWS       = LD_ROWS,
  parameter int ELEMS      = LD_ELEMS,
  parameter int ELEM_W     = LD_ELEM_W,
  parameter int META_W     = LD_META_W,
  parameter int META_DEPTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int SLOT_W     = ELEM_W + META_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_kind,
  input  logic [$clog2(NUM_REGS)-1:0]        cmd_reg,
  output logic                               rd_req,
  output logic [$clog2(NUM_REGS)-1:0]        rd_addr,
  input  logic [7:0]                         rd_data,
  input  logic                               rd_valid,
  output logic                               rd_ready,
  input  logic [META_W-1:0]                  meta_data,
  input  logic                               meta_valid,
  output logic                               meta_ready,
  output logic [ROWS-1:0][ELEMS*SLOT_W-1:0]  out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_kind,
  input  logic                               abort,
  output logic                               busy,
  output loader_state_e                      dbg_state,
  output logic [$clog2(META_DEPTH):0]        dbg_meta_count
);

  // Every channel transfers exactly on a cycle where valid && ready are both high;
  // valid never waits on ready, and ready may depend combinationally on state only.

  localparam int BPE = ELEM_W / 8;
  localparam int BCW = (BPE > 1)   ? $clog2(BPE)   : 1;
  localparam int ECW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int RCW = (ROWS > 1)  ? $clog2(ROWS)  : 1;

  if ((ELEM_W % 8) != 0 || ELEM_W < 8) begin : g_bad_elem_w
    $error("operand_row_loader: ELEM_W must be a non-zero multiple of 8");
  end
  if (META_DEPTH < 2 || (META_DEPTH & (META_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("operand_row_loader: META_DEPTH must be a power of 2 and at least 2");
  end

  loader_state_e                       r_state;
  loader_kind_e                        r_kind;
  logic [$clog2(NUM_REGS)-1:0]         r_addr;
  logic [BCW-1:0]                      r_byte_cnt;
  logic [ECW-1:0]                      r_elem_cnt;
  logic [RCW-1:0]                      r_row_cnt;
  logic [ROWS-1:0][ELEMS*SLOT_W-1:0]   r_out;

  logic              w_last_byte;
  logic              w_last_elem;
  logic              w_last_row;
  logic              w_meta_stall;
  logic              w_accept;
  logic              w_elem_done;
  logic              w_final;
  logic              w_cmd_acc;
  logic              w_pop;
  logic              w_flush;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [META_W-1:0] w_fifo_data;

  assign w_last_byte  = (r_byte_cnt == BCW'(BPE - 1));
  assign w_last_elem  = (r_elem_cnt == ECW'(ELEMS - 1));
  assign w_last_row   = (r_row_cnt == RCW'(ROWS - 1));
  assign w_meta_stall = (r_kind == LD_WEIGHT) && w_last_byte && w_fifo_empty;
  assign rd_ready     = (r_state == FETCH) && !w_meta_stall;
  assign w_accept     = rd_valid && rd_ready && !abort;
  assign w_elem_done  = w_accept && w_last_byte;
  assign w_final      = w_elem_done && w_last_elem && w_last_row;
  assign w_pop        = w_elem_done && (r_kind == LD_WEIGHT);
  assign w_cmd_acc    = cmd_valid && cmd_ready;
  assign w_flush      = abort && (r_state != IDLE) && (r_kind == LD_WEIGHT);

  assign cmd_ready      = (r_state == IDLE);
  assign busy           = (r_state != IDLE);
  assign rd_req         = (r_state == FETCH);
  assign rd_addr        = r_addr;
  assign out_valid      = (r_state == PRESENT);
  assign out_kind       = (r_kind == LD_ACC);
  assign out_data       = r_out;
  assign meta_ready     = !w_fifo_full;
  assign dbg_state      = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_kind     <= LD_WEIGHT;
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_elem_cnt <= '0;
      r_row_cnt  <= '0;
    end else if (abort) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_elem_cnt <= '0;
      r_row_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_cmd_acc) begin
          r_state    <= FETCH;
          r_kind     <= loader_kind_e'(cmd_kind);
          r_addr     <= cmd_reg;
          r_byte_cnt <= '0;
          r_elem_cnt <= '0;
          r_row_cnt  <= '0;
        end
        FETCH: if (w_accept) begin
          r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BCW'(1);
          if (w_last_byte) r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + ECW'(1);
          if (w_last_byte && w_last_elem) r_row_cnt <= w_last_row ? '0 : r_row_cnt + RCW'(1);
          if (w_final) r_state <= PRESENT;
        end
        PRESENT: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tile storage is not cleared between tiles: every slot is rewritten before PRESENT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (w_accept) begin
      r_out[r_row_cnt][r_elem_cnt*SLOT_W + META_W + r_byte_cnt*8 +: 8] <= rd_data;
      if (w_last_byte)
        r_out[r_row_cnt][r_elem_cnt*SLOT_W +: META_W] <= (r_kind == LD_WEIGHT) ? w_fifo_data : '0;
    end
  end

  loader_meta_fifo #(
    .WIDTH (META_W),
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (meta_valid),
    .i_data  (meta_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (dbg_meta_count)
  );

endmodule

// File: tb/tb_operand_row_loader.sv
// Self-checking bench for operand_row_loader: tile vectors through a scoreboard,
// plus hand sequences for meta starvation, abort, reset and FIFO-full corners.
module tb_operand_row_loader;
  import vTPU_pkg::*;

  localparam int ROWS = 2, ELEMS = 2, ELEM_W = 16, META_W = 2, META_DEPTH = 16, NUM_REGS = 8;
  localparam int SLOT_W = ELEM_W + META_W;
  localparam int TILE_W = ROWS * ELEMS * SLOT_W;
  localparam int W = TILE_W + 1;

  logic clk, rst_n;
  logic cmd_valid, cmd_ready, cmd_kind;
  logic [2:0] cmd_reg, rd_addr;
  logic rd_req, rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic [META_W-1:0] meta_data;
  logic meta_valid, meta_ready;
  logic [ROWS-1:0][ELEMS*SLOT_W-1:0] out_data;
  logic out_valid, out_ready, out_kind, abort, busy;
  loader_state_e dbg_state;
  logic [4:0] dbg_meta_count;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic              kind;
    logic [63:0]       bytes;
    logic [7:0]        metas;
    logic [TILE_W-1:0] exp;
    logic [7:0]        hold;
  } vec_t;
  vec_t vecs[3];

  operand_row_loader #(
    .ROWS(ROWS), .ELEMS(ELEMS), .ELEM_W(ELEM_W), .META_W(META_W),
    .META_DEPTH(META_DEPTH), .NUM_REGS(NUM_REGS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_reg(cmd_reg),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .meta_data(meta_data), .meta_valid(meta_valid), .meta_ready(meta_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .abort(abort), .busy(busy),
    .dbg_state(dbg_state), .dbg_meta_count(dbg_meta_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [TILE_W-1:0] tile_model(input logic kind, input logic [63:0] bytes,
                                                   input logic [7:0] metas);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int k = 0; k < ROWS * ELEMS; k++)
      t[k*SLOT_W +: SLOT_W] = {bytes[k*16+8 +: 8], bytes[k*16 +: 8], kind ? 2'b00 : metas[k*2 +: 2]};
    return t;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " rd_req"}, rd_req, 0);
    check({tag, " rd_addr"}, rd_addr, 0);
    check({tag, " rd_ready"}, rd_ready, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_data"}, out_data, 0);
    check({tag, " out_kind"}, out_kind, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " meta_ready"}, meta_ready, 1);
    check({tag, " cmd_ready"}, cmd_ready, 1);
    check({tag, " meta_count"}, dbg_meta_count, 0);
  endtask

  // Driver tasks: each starts and ends 1 time unit after a rising edge.
  task automatic push_meta(input logic [1:0] m);
    int n;
    meta_valid = 1'b1; meta_data = m; #1;
    n = 0;
    while (!meta_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!meta_ready) check("meta_ready timeout", meta_ready, 1);
    @(posedge clk); #1;
    meta_valid = 1'b0;
  endtask

  task automatic issue_cmd(input logic kind, input logic [2:0] reg_i);
    cmd_valid = 1'b1; cmd_kind = kind; cmd_reg = reg_i; #1;
    check("cmd_ready in idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; #1;
    check("rd_req after cmd", rd_req, 1);
    check("rd_addr after cmd", rd_addr, reg_i);
    check("busy after cmd", busy, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    rd_valid = 1'b1; rd_data = b; #1;
    n = 0;
    while (!rd_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!rd_ready) check("rd_ready timeout", rd_ready, 1);
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  // Scoreboard consumer: pops the expected tile when the DUT presents one.
  task automatic collect(input int hold);
    int n;
    logic [W-1:0] exp;
    #1;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #2; n++; end
    if (!out_valid) check("out_valid timeout", out_valid, 1);
    if (exp_q.size() == 0) begin
      check("unexpected tile", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      for (int c = 0; c < hold; c++) begin
        check("held tile", {out_kind, out_data}, exp);
        check("cmd_ready while held", cmd_ready, 0);
        @(posedge clk); #2;
      end
      check("tile", {out_kind, out_data}, exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; #1;
      check("idle after tile", dbg_state, IDLE);
      check("cmd_ready after tile", cmd_ready, 1);
      check("out_valid after tile", out_valid, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    logic [TILE_W-1:0] t;
    logic [63:0] rb;

    rst_n = 1'b1; cmd_valid = 0; cmd_kind = 0; cmd_reg = 0; rd_data = 0; rd_valid = 0;
    meta_data = 0; meta_valid = 0; out_ready = 0; abort = 0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0].kind  = 1'b0;
    vecs[0].bytes = 64'h8877_6655_4433_2211;
    vecs[0].metas = {2'd0, 2'd3, 2'd2, 2'd1};
    vecs[0].exp   = {16'h8877, 2'd0, 16'h6655, 2'd3, 16'h4433, 2'd2, 16'h2211, 2'd1};
    vecs[0].hold  = 8'd0;
    vecs[1].kind  = 1'b0;
    vecs[1].bytes = {$urandom, $urandom};
    vecs[1].metas = 8'($urandom_range(0, 255));
    vecs[1].exp   = tile_model(1'b0, vecs[1].bytes, vecs[1].metas);
    vecs[1].hold  = 8'd10;
    vecs[2].kind  = 1'b1;
    vecs[2].bytes = 64'h0807_0605_0403_0201;
    vecs[2].metas = 8'($urandom_range(0, 255));
    vecs[2].exp   = tile_model(1'b1, vecs[2].bytes, vecs[2].metas);
    vecs[2].hold  = 8'd3;

    for (int i = 0; i < 3; i++) begin
      v = vecs[i];
      for (int k = 0; k < 3; k++) push_meta(v.metas[k*2 +: 2]);
      #1 check("meta count prefill", dbg_meta_count, 3);
      @(posedge clk); #1;
      issue_cmd(v.kind, 3'(i + 1));
      exp_q.push_back({v.kind, v.exp});
      for (int b = 0; b < 8; b++) begin
        if (v.kind == 1'b0 && b == 1) begin
          rd_valid = 1'b1; rd_data = v.bytes[b*8 +: 8];
          meta_valid = 1'b1; meta_data = v.metas[7:6]; #1;
          check("rd_ready with meta", rd_ready, 1);
          check("meta_ready not full", meta_ready, 1);
          @(posedge clk); #1;
          rd_valid = 1'b0; meta_valid = 1'b0; #1;
          check("push+pop keeps count", dbg_meta_count, 3);
          @(posedge clk); #1;
        end else begin
          if (v.kind == 1'b1 && b == 1) begin
            cmd_valid = 1'b1; cmd_kind = 1'b0; cmd_reg = 3'd7; #1;
            check("cmd_ready busy", cmd_ready, 0);
            @(posedge clk); #1;
            cmd_valid = 1'b0; #1;
            check("rd_addr not requeued", rd_addr, 3'(i + 1));
            @(posedge clk); #1;
          end
          if (b == 7) begin
            #1 check("out_valid before last byte", out_valid, 0);
            @(posedge clk); #1;
          end
          send_byte(v.bytes[b*8 +: 8]);
        end
      end
      #1;
      check("out_valid latency", out_valid, 1);
      check("rd_req falls", rd_req, 0);
      collect(int'(v.hold));
      if (v.kind == 1'b1) begin
        #1 check("acc keeps meta", dbg_meta_count, 3);
        @(posedge clk); #1;
      end
    end

    // Abort after three bytes of a weight tile flushes the meta FIFO.
    issue_cmd(1'b0, 3'd4);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    #1 check("count before abort", dbg_meta_count, 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; #1;
    check("busy after abort", busy, 0);
    check("meta flushed", dbg_meta_count, 0);
    check("rd_req after abort", rd_req, 0);
    t = vecs[2].exp;
    t[SLOT_W-1:0] = {16'hA2A1, vecs[2].metas[1:0]};
    t[SLOT_W+META_W +: 8] = 8'hA3;
    check("abort holds out_data", out_data, t);
    @(posedge clk); #1;

    // Meta starvation on the element-completing byte.
    issue_cmd(1'b0, 3'd5);
    send_byte(8'hB1);
    rd_valid = 1'b1; rd_data = 8'hB2;
    for (int c = 0; c < 5; c++) begin
      #1 check("starved rd_ready", rd_ready, 0);
      @(posedge clk); #1;
    end
    meta_valid = 1'b1; meta_data = 2'd1; #1;
    check("starved during push", rd_ready, 0);
    @(posedge clk); #1;
    meta_valid = 1'b0; #1;
    check("rd_ready after meta", rd_ready, 1);
    check("count after meta", dbg_meta_count, 1);
    @(posedge clk); #1;
    rd_valid = 1'b0; #1;
    check("count after pop", dbg_meta_count, 0);
    @(posedge clk); #1;

    // Asynchronous reset mid-FETCH.
    send_byte(8'hB3);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check("no pulse after reset", {busy, out_valid}, 0);
      @(posedge clk); #1;
    end

    // FIFO boundary: full, then pop with a simultaneous push attempt.
    meta_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      meta_data = 2'(i);
      @(posedge clk); #1;
    end
    meta_valid = 1'b0; #1;
    check("meta_ready full", meta_ready, 0);
    check("count full", dbg_meta_count, 16);
    @(posedge clk); #1;
    rb = {$urandom, $urandom};
    issue_cmd(1'b0, 3'd6);
    exp_q.push_back({1'b0, tile_model(1'b0, rb, {2'd3, 2'd2, 2'd1, 2'd0})});
    send_byte(rb[7:0]);
    rd_valid = 1'b1; rd_data = rb[15:8]; meta_valid = 1'b1; meta_data = 2'd3; #1;
    check("meta_ready full with pop", meta_ready, 0);
    check("rd_ready with full fifo", rd_ready, 1);
    @(posedge clk); #1;
    rd_valid = 1'b0; #1;
    check("count after full pop", dbg_meta_count, 15);
    check("meta_ready after pop", meta_ready, 1);
    @(posedge clk); #1;
    meta_valid = 1'b0; #1;
    check("count refilled", dbg_meta_count, 16);
    check("meta_ready refilled", meta_ready, 0);
    @(posedge clk); #1;
    for (int b = 2; b < 8; b++) send_byte(rb[b*8 +: 8]);
    #1 check("out_valid latency full", out_valid, 1);
    collect(0);
    #1 check("count after tile", dbg_meta_count, 13);
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
